// File: rtl/rpn_calculator_if.sv
// rpn_calculator_if: command/operand inputs and stack status outputs of the RPN calculator core.
interface rpn_calculator_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] NumIn;
   logic [2:0]       OpIn;
   logic             Enter;
   logic [WIDTH-1:0] NumOut;
   logic [CW-1:0]    Count;
   logic             Carry;
   logic             Error;
   modport master (output NumIn, OpIn, Enter, input NumOut, Count, Carry, Error);
   modport slave  (input NumIn, OpIn, Enter, output NumOut, Count, Carry, Error);
endinterface

// File: rtl/rpn_calculator.sv
// rpn_calculator: DEPTH-entry RPN stack calculator; one command per rising edge of Enter.
module rpn_calculator #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic             clock,
   input logic             Reset,
   rpn_calculator_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_EQ   = 3'd5;
   localparam logic [2:0] OP_POP  = 3'd6;
   localparam logic [2:0] OP_CLR  = 3'd7;

   logic [WIDTH-1:0] stk_q [DEPTH];
   logic [WIDTH-1:0] stk_d [DEPTH];
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic             err_q, err_d;
   logic             en_q;

   logic             fire;
   logic [IW-1:0]    top, sec;
   logic [WIDTH-1:0] t, s, res;
   logic [WIDTH:0]   sum, diff;
   logic             cy;

   // Entry cnt_q-1 is the top; indices wrap harmlessly when the count is too small to use them.
   assign fire = bus.Enter & ~en_q;
   assign top  = IW'(cnt_q - CW'(1));
   assign sec  = IW'(cnt_q - CW'(2));
   assign t    = stk_q[top];
   assign s    = stk_q[sec];
   assign sum  = {1'b0, s} + {1'b0, t};
   assign diff = {1'b0, s} - {1'b0, t};
   assign res  = bus.OpIn == OP_ADD ? sum[WIDTH-1:0] :
                 bus.OpIn == OP_SUB ? diff[WIDTH-1:0] :
                 bus.OpIn == OP_OR  ? (s | t) :
                 bus.OpIn == OP_AND ? (s & t) : WIDTH'(s == t);
   assign cy   = bus.OpIn == OP_ADD ? sum[WIDTH] :
                 bus.OpIn == OP_SUB ? diff[WIDTH] : 1'b0;

   always_comb begin
      stk_d = stk_q;
      cnt_d = cnt_q;
      cy_d  = cy_q;
      err_d = err_q;
      if (fire) begin
         case (bus.OpIn)
            OP_PUSH:
               if (cnt_q < CW'(DEPTH)) begin
                  stk_d[IW'(cnt_q)] = bus.NumIn;
                  cnt_d = cnt_q + CW'(1);
                  cy_d  = 1'b0;
               end else err_d = 1'b1;
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_EQ:
               if (cnt_q >= CW'(2)) begin
                  stk_d[sec] = res;
                  cnt_d = cnt_q - CW'(1);
                  cy_d  = cy;
               end else err_d = 1'b1;
            OP_POP:
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
                  cy_d  = 1'b0;
               end else err_d = 1'b1;
            OP_CLR: begin
               cnt_d = '0;
               cy_d  = 1'b0;
               err_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         stk_q <= '{default: '0};
         cnt_q <= '0;
         cy_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         stk_q <= stk_d;
         cnt_q <= cnt_d;
         cy_q  <= cy_d;
         err_q <= err_d;
      end
   end

   // Edge history tracks Enter through reset so a held strobe cannot fire on release.
   always_ff @(posedge clock) en_q <= bus.Enter;

   assign bus.NumOut = cnt_q == '0 ? '0 : t;
   assign bus.Count  = cnt_q;
   assign bus.Carry  = cy_q;
   assign bus.Error  = err_q;
endmodule

// File: tb/tb_rpn_calculator.sv
// tb_rpn_calculator: directed RPN command vectors checked through an expectation queue and monitor.
module tb_rpn_calculator;
   typedef struct packed {
      logic [7:0] n;
      logic [2:0] c;
      logic       cy;
      logic       er;
   } exp_t;

   logic clock = 1'b0;
   logic Reset = 1'b1;
   rpn_calculator_if #(.WIDTH(8), .DEPTH(4)) bus ();

   rpn_calculator #(.WIDTH(8), .DEPTH(4)) dut (.clock(clock), .Reset(Reset), .bus(bus));

   always #5 clock = ~clock;

   exp_t  exp_q [$];
   string name_q [$];
   int    errors = 0;
   int    checks = 0;
   int    probe_cnt = 0;
   int    seen_cnt = 0;
   logic  fire_seen = 1'b0;
   logic  en_prev = 1'b0;

   always @(posedge clock) begin
      fire_seen <= bus.Enter & ~en_prev & ~Reset;
      en_prev   <= bus.Enter;
   end

   always @(negedge clock) begin
      if (fire_seen || probe_cnt != seen_cnt) begin
         exp_t  e;
         exp_t  g;
         string nm;
         if (probe_cnt != seen_cnt) seen_cnt++;
         checks++;
         g = '{bus.NumOut, bus.Count, bus.Carry, bus.Error};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got num=%h cnt=%0d cy=%b err=%b, no expectation queued",
                     g.n, g.c, g.cy, g.er);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL %s got num=%h cnt=%0d cy=%b err=%b expected num=%h cnt=%0d cy=%b err=%b",
                        nm, g.n, g.c, g.cy, g.er, e.n, e.c, e.cy, e.er);
            end
         end
      end
   end

   task automatic expect_out(input string nm, input logic [7:0] n, input logic [2:0] c,
                             input logic cy, input logic er);
      exp_q.push_back('{n, c, cy, er});
      name_q.push_back(nm);
   endtask

   task automatic cmd(input string nm, input logic [2:0] op, input logic [7:0] num,
                      input logic [7:0] n, input logic [2:0] c, input logic cy, input logic er);
      @(negedge clock); #1;
      bus.OpIn = op;
      bus.NumIn = num;
      bus.Enter = 1'b1;
      expect_out(nm, n, c, cy, er);
      @(negedge clock); #1;
      bus.Enter = 1'b0;
   endtask

   task automatic probe(input string nm, input logic [7:0] n, input logic [2:0] c,
                        input logic cy, input logic er);
      @(posedge clock); #1;
      expect_out(nm, n, c, cy, er);
      probe_cnt++;
      @(negedge clock); #1;
   endtask

   initial begin
      repeat (5000) @(posedge clock);
      errors++;
      checks++;
      $display("FAIL timeout got still running expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

   initial begin
      bus.OpIn = 3'd0;
      bus.NumIn = 8'd0;
      bus.Enter = 1'b0;
      repeat (2) @(negedge clock);
      #1 Reset = 1'b0;
      probe("reset", 8'd0, 3'd0, 1'b0, 1'b0);

      cmd("t1_push5", 3'd0, 8'd5, 8'd5, 3'd1, 1'b0, 1'b0);
      cmd("t1_push3", 3'd0, 8'd3, 8'd3, 3'd2, 1'b0, 1'b0);
      cmd("t1_sub",   3'd2, 8'd0, 8'd2, 3'd1, 1'b0, 1'b0);
      cmd("t1_clr",   3'd7, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

      cmd("t2_push3", 3'd0, 8'd3,   8'd3,   3'd1, 1'b0, 1'b0);
      cmd("t2_push5", 3'd0, 8'd5,   8'd5,   3'd2, 1'b0, 1'b0);
      cmd("t2_sub",   3'd2, 8'd0,   8'hFE,  3'd1, 1'b1, 1'b0);
      cmd("t2_pushfe",3'd0, 8'hFE,  8'hFE,  3'd2, 1'b0, 1'b0);
      cmd("t2_eq",    3'd5, 8'd0,   8'd1,   3'd1, 1'b0, 1'b0);
      cmd("t2_push2", 3'd0, 8'd2,   8'd2,   3'd2, 1'b0, 1'b0);
      cmd("t2_eq_ne", 3'd5, 8'd0,   8'd0,   3'd1, 1'b0, 1'b0);
      cmd("t2_clr",   3'd7, 8'd0,   8'd0,   3'd0, 1'b0, 1'b0);

      cmd("t3_push200", 3'd0, 8'd200, 8'd200, 3'd1, 1'b0, 1'b0);
      cmd("t3_push100", 3'd0, 8'd100, 8'd100, 3'd2, 1'b0, 1'b0);
      cmd("t3_add",     3'd1, 8'd0,   8'd44,  3'd1, 1'b1, 1'b0);
      cmd("t3_add_few", 3'd1, 8'd0,   8'd44,  3'd1, 1'b1, 1'b1);
      cmd("t3_push0f",  3'd0, 8'h0F,  8'h0F,  3'd2, 1'b0, 1'b1);
      cmd("t3_and",     3'd4, 8'd0,   8'h0C,  3'd1, 1'b0, 1'b1);
      cmd("t3_push30",  3'd0, 8'h30,  8'h30,  3'd2, 1'b0, 1'b1);
      cmd("t3_or",      3'd3, 8'd0,   8'h3C,  3'd1, 1'b0, 1'b1);
      cmd("t3_clr",     3'd7, 8'd0,   8'd0,   3'd0, 1'b0, 1'b0);

      for (int i = 1; i <= 4; i++)
         cmd("t4_push", 3'd0, 8'(i), 8'(i), 3'(i), 1'b0, 1'b0);
      cmd("t4_push_full", 3'd0, 8'd5, 8'd4, 3'd4, 1'b0, 1'b1);
      cmd("t4_pop",       3'd6, 8'd0, 8'd3, 3'd3, 1'b0, 1'b1);
      cmd("t4_clr",       3'd7, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
      cmd("t4_pop_empty", 3'd6, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1);
      cmd("t4_clr2",      3'd7, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

      @(negedge clock); #1;
      bus.OpIn = 3'd0;
      bus.NumIn = 8'd7;
      bus.Enter = 1'b1;
      expect_out("t5_first_edge", 8'd7, 3'd1, 1'b0, 1'b0);
      repeat (4) @(negedge clock);
      #1 bus.NumIn = 8'd9;
      repeat (5) @(negedge clock);
      probe("t5_held", 8'd7, 3'd1, 1'b0, 1'b0);
      bus.Enter = 1'b0;

      cmd("t6_push2", 3'd0, 8'd2, 8'd2, 3'd2, 1'b0, 1'b0);
      cmd("t6_push3", 3'd0, 8'd3, 8'd3, 3'd3, 1'b0, 1'b0);
      @(negedge clock); #1;
      bus.OpIn = 3'd1;
      bus.Enter = 1'b1;
      Reset = 1'b1;
      @(negedge clock); #1;
      Reset = 1'b0;
      repeat (3) @(negedge clock);
      probe("t6_reset_held", 8'd0, 3'd0, 1'b0, 1'b0);
      bus.Enter = 1'b0;
      cmd("t6_add_empty", 3'd1, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1);
      cmd("t6_push_err",  3'd0, 8'd9, 8'd9, 3'd1, 1'b0, 1'b1);
      cmd("t6_clr",       3'd7, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

      repeat (3) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
